// File: rtl/scan_pkg.sv
// Shared timing constants, region encoding and region classifier for the
// tile-map scan scheduler.
package scan_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int TILE_PX  = 20;
  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_HBLANK = 2'd1,
    S_VBLANK = 2'd2
  } region_t;

  function automatic region_t region_of(input logic [9:0] row, input logic [9:0] col,
                                        input logic [9:0] h_act, input logic [9:0] v_act);
    if (col >= v_act) return S_VBLANK;
    if (row >= h_act) return S_HBLANK;
    return S_ACTIVE;
  endfunction

endpackage

// File: rtl/scan_scheduler_if.sv
// Game-logic tile write channel plus the single-port tile RAM bus.
interface scan_scheduler_if;
  logic       wr_req;
  logic [9:0] wr_addr;
  logic [1:0] wr_data;
  logic       wr_gnt;
  logic [9:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  modport master (input wr_req, wr_addr, wr_data, mem_rdata,
                  output wr_gnt, mem_addr, mem_we, mem_wdata);
  modport slave  (output wr_req, wr_addr, wr_data, mem_rdata,
                  input wr_gnt, mem_addr, mem_we, mem_wdata);
endinterface

// File: rtl/scan_counter.sv
// Pixel/line counter with modulo-TILE_PX sub-counters and tile x/y indices,
// so the tile address needs no divider. TILE_PX must be 32 or less.
module scan_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int TILE_PX = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] row_o,
  output logic [9:0] col_o,
  output logic [9:0] row_d_o,
  output logic [9:0] col_d_o,
  output logic       x_edge_o,
  output logic [4:0] tile_x_o,
  output logic [4:0] tile_y_o,
  output logic       frame_wrap_o
);
  localparam logic [9:0] ROW_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] COL_LAST = 10'(V_TOTAL - 1);
  localparam logic [4:0] SUB_LAST = 5'(TILE_PX - 1);

  logic [9:0] row_q, row_d, col_q, col_d;
  logic [4:0] hx_q, hx_d, vy_q, vy_d;
  logic [5:0] tx_q, tx_d, ty_q, ty_d;
  logic       line_end, frame_end;

  assign line_end  = (row_q == ROW_LAST);
  assign frame_end = line_end && (col_q == COL_LAST);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    hx_d  = hx_q;
    vy_d  = vy_q;
    tx_d  = tx_q;
    ty_d  = ty_q;
    if (pix_en) begin
      if (line_end) begin
        row_d = '0;
        hx_d  = '0;
        tx_d  = '0;
        if (frame_end) begin
          col_d = '0;
          vy_d  = '0;
          ty_d  = '0;
        end else begin
          col_d = col_q + 10'd1;
          if (vy_q == SUB_LAST) begin
            vy_d = '0;
            ty_d = ty_q + 6'd1;
          end else begin
            vy_d = vy_q + 5'd1;
          end
        end
      end else begin
        row_d = row_q + 10'd1;
        if (hx_q == SUB_LAST) begin
          hx_d = '0;
          tx_d = tx_q + 6'd1;
        end else begin
          hx_d = hx_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      hx_q  <= '0;
      vy_q  <= '0;
      tx_q  <= '0;
      ty_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      hx_q  <= hx_d;
      vy_q  <= vy_d;
      tx_q  <= tx_d;
      ty_q  <= ty_d;
    end
  end

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign row_d_o      = row_d;
  assign col_d_o      = col_d;
  assign x_edge_o     = (hx_q == 5'd0);
  assign tile_x_o     = tx_q[4:0];
  assign tile_y_o     = ty_q[4:0];
  assign frame_wrap_o = pix_en && frame_end;
endmodule

// File: rtl/scan_scheduler.sv
// Raster scan scheduler: region FSM, display tile fetch pipeline and
// arbitration of game-logic writes onto the shared tile RAM port.
module scan_scheduler #(
  parameter int H_TOTAL = scan_pkg::H_TOTAL,
  parameter int V_TOTAL = scan_pkg::V_TOTAL,
  parameter int TILE_PX = scan_pkg::TILE_PX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  scan_scheduler_if.master  bus,
  output logic [9:0]        row,
  output logic [9:0]        col,
  output logic              vblank,
  output logic              frame_start,
  output logic [1:0]        tile,
  output logic              tile_valid
);
  import scan_pkg::*;

  localparam logic [9:0] H_ACT = 10'(GRID_W * TILE_PX);
  localparam logic [9:0] V_ACT = 10'(GRID_H * TILE_PX);

  region_t    state_q, state_d;
  logic [9:0] row_d, col_d;
  logic       x_edge, frame_wrap;
  logic [4:0] tile_x, tile_y;
  logic       fetch, gnt;
  logic [9:0] addr_q;
  logic [1:0] wdata_q;
  logic       fetch_q;
  logic [1:0] tile_q;
  logic       tile_valid_q;
  logic       frame_start_q;

  scan_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .TILE_PX(TILE_PX)) u_counter (
    .clk          (clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .row_o        (row),
    .col_o        (col),
    .row_d_o      (row_d),
    .col_d_o      (col_d),
    .x_edge_o     (x_edge),
    .tile_x_o     (tile_x),
    .tile_y_o     (tile_y),
    .frame_wrap_o (frame_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_ACTIVE;
    else       state_q <= state_d;
  end

  // Region is classified from the counters' next value so it always matches row/col.
  always_comb begin
    state_d = region_of(row_d, col_d, H_ACT, V_ACT);
  end

  always_comb begin
    fetch         = pix_en && !reset && (state_q == S_ACTIVE) && x_edge;
    gnt           = bus.wr_req && !reset && (state_q != S_ACTIVE) && !fetch;
    bus.wr_gnt    = gnt;
    bus.mem_we    = gnt;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    if (fetch) begin
      bus.mem_addr = {tile_y, tile_x};
    end else if (gnt) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      fetch_q       <= 1'b0;
      tile_q        <= '0;
      tile_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      addr_q        <= bus.mem_addr;
      wdata_q       <= bus.mem_wdata;
      fetch_q       <= fetch;
      frame_start_q <= frame_wrap;
      if (fetch_q) tile_q <= bus.mem_rdata;
      if (pix_en)  tile_valid_q <= (state_q == S_ACTIVE);
    end
  end

  assign vblank      = (state_q == S_VBLANK);
  assign frame_start = frame_start_q;
  assign tile        = tile_q;
  assign tile_valid  = tile_valid_q;
endmodule

// File: tb/tb_scan_scheduler.sv
// Randomised bench for scan_scheduler on a reduced raster (80x53, 2-pixel tiles)
// with a behavioural raster/RAM model and a per-cycle output compare.
module tb_scan_scheduler;
  localparam int HT = 80;
  localparam int VT = 53;
  localparam int TP = 2;
  localparam int HA = 32 * TP;
  localparam int VA = 24 * TP;

  logic       clk;
  logic       reset;
  logic       pix_en;
  logic [9:0] row, col;
  logic       vblank, frame_start, tile_valid;
  logic [1:0] tile;

  scan_scheduler_if bus ();

  scan_scheduler #(.H_TOTAL(HT), .V_TOTAL(VT), .TILE_PX(TP)) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .bus         (bus),
    .row         (row),
    .col         (col),
    .vblank      (vblank),
    .frame_start (frame_start),
    .tile        (tile),
    .tile_valid  (tile_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tile RAM seen by the DUT: registered read, read-before-write.
  logic [1:0] ram [1024] = '{default: 2'b00};
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pixel position, expected tile pipeline, and model RAM.
  logic [1:0] mram [1024] = '{default: 2'b00};
  int   m_row, m_col, m_addr, m_wd, m_tile, m_pend_val, m_fa;
  bit   m_tv, m_fs, m_pend, m_addr_known, m_wd_known, m_act, m_f, m_g;

  always @(posedge clk) begin
    m_act = (m_row < HA) && (m_col < VA);
    if (reset) begin
      m_row = 0; m_col = 0; m_tile = 0; m_tv = 0; m_fs = 0; m_pend = 0;
      m_addr_known = 0; m_wd_known = 0;
    end else begin
      m_f  = pix_en && m_act && (m_row % TP == 0);
      m_g  = bus.wr_req && !m_act;
      m_fa = (m_col / TP) * 32 + m_row / TP;
      if (m_pend) m_tile = m_pend_val;
      m_pend = m_f;
      if (m_f) m_pend_val = mram[m_fa];
      if (m_g) begin
        mram[bus.wr_addr] = bus.wr_data;
        m_addr = bus.wr_addr; m_addr_known = 1;
        m_wd   = bus.wr_data; m_wd_known   = 1;
      end else if (m_f) begin
        m_addr = m_fa; m_addr_known = 1;
      end
      m_fs = pix_en && (m_row == HT - 1) && (m_col == VT - 1);
      if (pix_en) begin
        m_tv = m_act;
        if (m_row == HT - 1) begin
          m_row = 0;
          m_col = (m_col == VT - 1) ? 0 : m_col + 1;
        end else begin
          m_row = m_row + 1;
        end
      end
    end
  end

  bit chk_on = 0;
  bit c_act, c_f, c_g;
  always @(negedge clk) begin
    if (chk_on) begin
      c_act = (m_row < HA) && (m_col < VA);
      c_f   = pix_en && !reset && c_act && (m_row % TP == 0);
      c_g   = bus.wr_req && !reset && !c_act;
      chk("row", row, m_row);
      chk("col", col, m_col);
      chk("vblank", vblank, m_col >= VA);
      chk("frame_start", frame_start, m_fs);
      chk("tile", tile, m_tile);
      chk("tile_valid", tile_valid, m_tv);
      chk("wr_gnt", bus.wr_gnt, c_g);
      chk("mem_we", bus.mem_we, c_g);
      if (c_f) begin
        chk("fetch_addr", bus.mem_addr, (m_col / TP) * 32 + m_row / TP);
      end else if (c_g) begin
        chk("write_addr", bus.mem_addr, bus.wr_addr);
        chk("write_data", bus.mem_wdata, bus.wr_data);
      end else begin
        if (m_addr_known) chk("idle_addr", bus.mem_addr, m_addr);
        if (m_wd_known)   chk("idle_wdata", bus.mem_wdata, m_wd);
      end
    end
  end

  // Stimulus helpers: half() samples at the falling edge, advance() crosses the rising edge.
  int  cyc;
  bit  g_seen;
  int  fs_log[$];

  task automatic half();
    @(negedge clk);
    g_seen = bus.wr_gnt;
    if (frame_start) fs_log.push_back(cyc);
  endtask

  task automatic new_req();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 10'($urandom_range(0, 1023));
    if (bus.wr_addr == 10'd404) bus.wr_addr = 10'd405;
    bus.wr_data = 2'($urandom_range(0, 3));
  endtask

  task automatic advance(input bit rand_wr);
    @(posedge clk);
    #1;
    cyc++;
    if (rand_wr) begin
      if (g_seen) bus.wr_req = 1'b0;
      if (!bus.wr_req && ($urandom_range(0, 1) == 1)) new_req();
    end
  endtask

  int n, grants, waited, f0, f1;
  bit got;
  logic [9:0] a_exp;

  initial begin
    reset = 1'b1; pix_en = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    @(posedge clk); #1;
    chk_on = 1;
    advance(0); advance(0);

    // Two full frames at pix_en=1 with random writes; a known tile is planted at 404.
    reset = 1'b0; pix_en = 1'b1; cyc = 0;
    bus.wr_req = 1'b1; bus.wr_addr = 10'd404; bus.wr_data = 2'b10;
    half();
    chk("rst_row", row, 0); chk("rst_col", col, 0);
    chk("rst_tile_valid", tile_valid, 0); chk("rst_frame_start", frame_start, 0);
    chk("rst_tile", tile, 0);
    advance(1);
    for (int k = 1; k < 8491; k++) begin
      half();
      if (k == 64)   chk("plant_gnt", bus.wr_gnt, 1);
      if (k == 2040) begin
        chk("lit_fetch_addr", bus.mem_addr, 404);
        chk("lit_fetch_we", bus.mem_we, 0);
      end
      if (k == 2042) chk("lit_tile", tile, 2);
      advance(1);
    end
    f0 = (fs_log.size() > 0) ? fs_log[0] : -1;
    f1 = (fs_log.size() > 1) ? fs_log[1] : -1;
    chk("fs_count", fs_log.size(), 2);
    chk("fs_first_cycle", f0, 4240);
    chk("fs_second_cycle", f1, 8480);

    // pix_en 1-0-0-1 inside the active area.
    bus.wr_req = 1'b0;
    half(); chk("gap_row_start", row, 11); chk("gap_tv_a", tile_valid, 1);
    advance(0); pix_en = 1'b0;
    half(); chk("gap_tv_b", tile_valid, 1);
    advance(0);
    half(); chk("gap_tv_c", tile_valid, 1); chk("gap_row_hold", row, 12);
    advance(0); pix_en = 1'b1;
    half(); chk("gap_tv_d", tile_valid, 1);
    advance(0);
    half(); chk("gap_row_end", row, 13);
    advance(0);

    // Request raised mid-active line waits for horizontal blanking.
    n = 0;
    while (!(m_row == 30 && m_col == 10) && n < 3000) begin half(); advance(0); n++; end
    chk("reach_10_30", n < 3000, 1);
    new_req(); a_exp = bus.wr_addr;
    waited = 0; got = 0;
    while (!got && waited < 200) begin
      half();
      if (bus.wr_gnt) begin
        got = 1;
        chk("hb_gnt_row", row, 64); chk("hb_gnt_col", col, 10);
        chk("hb_gnt_we", bus.mem_we, 1); chk("hb_gnt_addr", bus.mem_addr, a_exp);
        chk("hb_wait", waited, 34);
      end
      advance(0);
      waited++;
    end
    chk("hb_grant_seen", got, 1);
    bus.wr_req = 1'b0;

    // Continuous requests across the whole vertical blanking interval.
    n = 0;
    while (!(m_row == 0 && m_col == VA) && n < 6000) begin half(); advance(0); n++; end
    chk("reach_vblank", n < 6000, 1);
    grants = 0;
    for (int k = 0; k < (VT - VA) * HT; k++) begin
      new_req();
      half();
      if (bus.wr_gnt) grants++;
      advance(0);
    end
    new_req();
    half();
    chk("vb_grants", grants, (VT - VA) * HT);
    chk("wrap_gnt", bus.wr_gnt, 0); chk("wrap_addr", bus.mem_addr, 0);
    chk("wrap_we", bus.mem_we, 0); chk("wrap_row", row, 0); chk("wrap_col", col, 0);
    advance(0);
    bus.wr_req = 1'b0;

    // Random pix_en and writes, then a reset pulse in horizontal blanking with a pending write.
    n = 0;
    while (!(m_row == 70 && m_col == 30) && n < 9000) begin
      pix_en = ($urandom_range(0, 3) != 0);
      half(); advance(1); n++;
    end
    chk("reach_30_70", n < 9000, 1);
    if (!bus.wr_req) new_req();
    reset = 1'b1;
    half(); chk("rst_cycle_gnt", bus.wr_gnt, 0);
    advance(0);
    reset = 1'b0; pix_en = 1'b1; bus.wr_req = 1'b0;
    half();
    chk("post_rst_row", row, 0); chk("post_rst_col", col, 0);
    chk("post_rst_tv", tile_valid, 0); chk("post_rst_fs", frame_start, 0);
    advance(0);
    for (int k = 0; k < 300; k++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      half(); advance(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
